dac_stream_core: RTL
====================

# dac_stream_core

Sample-streaming engine between the PLB DAC register slave and the external 10-bit DAC pins. Buffers processor-written samples in a FIFO, releases one sample per programmable sample period, and generates the DAC data clock with data changing half a period before the latching edge. Reports underrun and overflow as sticky flags and registers the static DAC mode pins (Format, PinMD, ClkMD, PWRDN).

## Interface

Parameters:
- C_FIFO_DEPTH, 16: sample FIFO depth; power of two, at least 2. L = log2(C_FIFO_DEPTH).
- C_DIV_WIDTH, 16: width of the sample-period divider.

Ports (one clock; reset is asynchronous and active-high):
- Bus2IP_Clk  in  1  system clock; all logic on the rising edge.
- Bus2IP_Reset  in  1  asynchronous, active-high reset.
- wr_data  in  [0:9]  sample to enqueue; bit 0 is the MSB.
- wr_en  in  1  enqueue strobe, one sample per cycle.
- fifo_full  out  1  FIFO holds C_FIFO_DEPTH samples.
- fifo_level  out  L+1  current occupancy.
- enable  in  1  streaming enable.
- div  in  C_DIV_WIDTH  sample period P = max(div,1)+1 clocks.
- fmt_sel, pin_md, clk_md, pwrdn  in  1 each  mode controls, registered to pins.
- underrun_clr, overflow_clr  in  1  clear sticky flags.
- underrun, overflow  out  1  sticky status.
- S_Data  out  [0:9]  DAC data.
- S_Clkout, S_DCLKIO  out  1  DAC sample clock; identical registered copies.
- S_Format, S_PinMD, S_ClkMD, S_PWRDN  out  1  registered mode pins.

## Operation

- FIFO: circular buffer with L-bit read/write pointers and an (L+1)-bit level counter. Pointers wrap modulo C_FIFO_DEPTH.
- Write path: wr_en with fifo_full=0 stores the sample and increments level. wr_en with fifo_full=1 drops the sample, sets overflow, and leaves the FIFO unchanged. A pop in the same cycle does not make room; fullness is evaluated before the pop.
- Divider: div_q latches max(div,1) while enable=0 and at every period end. Changes to div mid-period take effect at the next period boundary. The phase counter runs 0..div_q.
- States:
  - IDLE (enable=0): phase held at div_q; S_Clkout=0; S_Data holds its last value.
  - RUN (enable=1): phase increments each cycle and wraps from div_q to 0. A period end is any cycle with phase==div_q.
- Entering RUN: the first enabled cycle is a period end, so the first sample pops immediately.
- At period end:
  - If level>0: pop the head into S_Data, effective next cycle.
  - If level=0: S_Data holds its value and underrun is set.
  - A write to an empty FIFO in the same cycle is stored, not popped.
- Clock: S_Clkout is registered as (phase_next ≥ H), where H = (div_q+1)>>1.
  - Low for H cycles starting with the cycle S_Data changes, then high for P−H cycles.
  - The DAC latches on the rising edge.
- Disabling: takes effect the next cycle. Phase returns to div_q, S_Clkout→0, and FIFO contents are retained.
- Flags: the clear strobe wins over a simultaneous set.
- Mode pins: each is a one-register copy of its input.

## Timing

- Reset values: S_Data=0, S_Clkout=S_DCLKIO=0, S_Format=0, S_PinMD=0, S_ClkMD=0, S_PWRDN=1 (powered down), fifo_level=0, fifo_full=0, underrun=0, overflow=0, phase=div_q=1.
- Reset asserted mid-stream clears the FIFO and all state asynchronously. Operation resumes on the first clock after deassertion.
- Write to fifo_level update: 1 cycle. fifo_full asserts the cycle after the C_FIFO_DEPTH-th accepted write.
- enable rise (cycle 0) to first S_Data update: cycle 1. First S_Clkout rise: cycle 1+H.
- Sample rate is Bus2IP_Clk/P exactly, with no gaps between periods.
- Mode pin latency: 1 cycle.

## Test plan

- Reset: assert Bus2IP_Reset mid-stream with FIFO level 5 -> all outputs at their reset values immediately, including S_PWRDN=1 and level=0.
- Basic stream: div=3, write 0x001,0x002,0x003, then enable -> S_Data steps through 1,2,3 every 4 cycles; S_Clkout is low 2 cycles and high 2 cycles per sample, rising 2 cycles after each data change.
- Underrun: continue the basic stream past the third sample -> S_Data holds 0x003 and underrun=1. Pulse underrun_clr -> underrun=0, then it re-sets at the next empty period end.
- Overflow/full: DEPTH=16, enable=0, write 17 samples -> fifo_full=1, level=16, overflow=1; the 17th sample is absent from the output sequence. Wrap: stream 40 samples with continuous refill -> output order preserved across pointer wrap.
- div edge cases: div=0 -> P=2, S_Clkout alternates each cycle with one sample per 2 cycles. Change div from 3 to 7 mid-period -> the current period completes at 4 cycles, then periods are 8 cycles with H=4.
- Simultaneous events: empty FIFO, write 0x155 on a period-end cycle -> underrun=1, level=1, and 0x155 appears on the following period end.

Source files
------------

// File: rtl/dac_stream_core.sv
// Buffers bus-written samples and releases one per programmable period to a 10-bit DAC, data changing half a period before the rising data clock.
// Pop-to-pin latency 1 cycle; no backpressure: writes to a full FIFO are dropped and flagged, empty periods hold the last sample and flag underrun.
module dac_stream_core #(
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_DIV_WIDTH  = 16
) (
  input  logic                            Bus2IP_Clk,
  input  logic                            Bus2IP_Reset,
  input  logic [0:9]                      wr_data,
  input  logic                            wr_en,
  output logic                            fifo_full,
  output logic [$clog2(C_FIFO_DEPTH):0]   fifo_level,
  input  logic                            enable,
  input  logic [C_DIV_WIDTH-1:0]          div,
  input  logic                            fmt_sel,
  input  logic                            pin_md,
  input  logic                            clk_md,
  input  logic                            pwrdn,
  input  logic                            underrun_clr,
  input  logic                            overflow_clr,
  output logic                            underrun,
  output logic                            overflow,
  output logic [0:9]                      S_Data,
  output logic                            S_Clkout,
  output logic                            S_DCLKIO,
  output logic                            S_Format,
  output logic                            S_PinMD,
  output logic                            S_ClkMD,
  output logic                            S_PWRDN
);
  localparam int L   = $clog2(C_FIFO_DEPTH);
  localparam int LW  = L + 1;
  localparam int DW1 = C_DIV_WIDTH + 1;

  logic [0:9]             mem [C_FIFO_DEPTH];
  logic [L-1:0]           wr_ptr, rd_ptr;
  logic [L:0]             level_q, level_d;
  logic [C_DIV_WIDTH-1:0] div_q, phase_q, div_eff, div_d, phase_d;
  logic [DW1-1:0]         half_d;
  logic                   period_end, push, pop, clk_d;

  assign div_eff    = (div == '0) ? C_DIV_WIDTH'(1) : div;
  assign period_end = enable && (phase_q == div_q);
  assign fifo_full  = (level_q == LW'(C_FIFO_DEPTH));
  assign fifo_level = level_q;
  // Fullness is judged before any same-cycle pop, so a pop never makes room.
  assign push       = wr_en && !fifo_full;
  assign pop        = period_end && (level_q != '0);

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    level_d = level_q;
    if (!enable) begin
      div_d   = div_eff;
      phase_d = div_eff;
    end else if (period_end) begin
      div_d   = div_eff;
      phase_d = '0;
    end else begin
      phase_d = phase_q + C_DIV_WIDTH'(1);
    end
    // Half-period threshold follows the divider governing the next cycle's period.
    half_d = ({1'b0, div_d} + DW1'(1)) >> 1;
    clk_d  = enable && ({1'b0, phase_d} >= half_d);
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      div_q    <= C_DIV_WIDTH'(1);
      phase_q  <= C_DIV_WIDTH'(1);
      S_Data   <= '0;
      S_Clkout <= 1'b0;
      S_DCLKIO <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      S_Format <= 1'b0;
      S_PinMD  <= 1'b0;
      S_ClkMD  <= 1'b0;
      S_PWRDN  <= 1'b1;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      level_q  <= level_d;
      S_Clkout <= clk_d;
      S_DCLKIO <= clk_d;
      if (push) begin
        wr_ptr <= wr_ptr + L'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + L'(1);
        S_Data <= mem[rd_ptr];
      end
      if (underrun_clr) begin
        underrun <= 1'b0;
      end else if (period_end && (level_q == '0)) begin
        underrun <= 1'b1;
      end
      if (overflow_clr) begin
        overflow <= 1'b0;
      end else if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end
      S_Format <= fmt_sel;
      S_PinMD  <= pin_md;
      S_ClkMD  <= clk_md;
      S_PWRDN  <= pwrdn;
    end
  end
endmodule
